// File: rtl/gpio_arb_pkg.sv
// Shared types and default widths for the GPIO output-port arbiter.
package gpio_arb_pkg;

    localparam int GPIO_ADDR_W = 32;
    localparam int GPIO_DATA_W = 8;

    typedef enum logic {IDLE, SEND} state_e;
    typedef enum logic {SRC_CPU, SRC_DBG} src_e;

endpackage

// File: rtl/gpio_arbiter_if.sv
// Processor, debug and GPIO-pin signals of the arbiter, bundled for port connection.
interface gpio_arbiter_if #(
    parameter int ADDR_W = gpio_arb_pkg::GPIO_ADDR_W,
    parameter int DATA_W = gpio_arb_pkg::GPIO_DATA_W
);
    logic              cpu_en;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data;
    logic              cpu_stall;
    logic              cpu_ovf;
    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic              dbg_gnt;
    logic              gpio_rdy;
    logic [ADDR_W-1:0] GPIOaddr;
    logic [DATA_W-1:0] GPIO;
    logic              GPIOEn;

    modport master (
        output cpu_en, cpu_addr, cpu_data, dbg_req, dbg_addr, dbg_data, gpio_rdy,
        input  cpu_stall, cpu_ovf, dbg_gnt, GPIOaddr, GPIO, GPIOEn
    );

    modport slave (
        input  cpu_en, cpu_addr, cpu_data, dbg_req, dbg_addr, dbg_data, gpio_rdy,
        output cpu_stall, cpu_ovf, dbg_gnt, GPIOaddr, GPIO, GPIOEn
    );

endinterface

// File: rtl/gpio_fifo.sv
// Synchronous FIFO buffering processor GPIO writes; head word is visible combinationally.
module gpio_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 40
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_din,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + PTR_W'(1);
            if (i_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/gpio_arbiter.sv
// Round-robin sharing of the GPIO output port between the buffered processor
// store path and the debug port; each beat is held until the peripheral accepts it.
module gpio_arbiter import gpio_arb_pkg::*; #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = GPIO_ADDR_W,
    parameter int DATA_W = GPIO_DATA_W
) (
    input  logic           clk,
    input  logic           rst,
    gpio_arbiter_if.slave  bus
);
    localparam int W     = ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [W-1:0]      w_head;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic              w_push;
    logic              w_gnt_cpu;
    logic              w_gnt_dbg;
    state_e            w_next;

    state_e            r_state;
    src_e              r_last;
    logic [ADDR_W-1:0] r_gpio_addr;
    logic [DATA_W-1:0] r_gpio_data;
    logic              r_gpio_en;
    logic              r_ovf;

    assign w_push = bus.cpu_en && !w_full;

    gpio_fifo #(.DEPTH(DEPTH), .WIDTH(W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   ({bus.cpu_addr, bus.cpu_data}),
        .i_pop   (w_gnt_cpu),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Grants are suppressed while rst is high so nothing is captured or popped.
    always_comb begin
        w_next    = r_state;
        w_gnt_cpu = 1'b0;
        w_gnt_dbg = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (!w_empty && bus.dbg_req) begin
                        if (r_last == SRC_DBG) w_gnt_cpu = 1'b1;
                        else                   w_gnt_dbg = 1'b1;
                    end else if (!w_empty) begin
                        w_gnt_cpu = 1'b1;
                    end else if (bus.dbg_req) begin
                        w_gnt_dbg = 1'b1;
                    end
                    if (w_gnt_cpu || w_gnt_dbg) w_next = SEND;
                end
                SEND: begin
                    if (bus.gpio_rdy) w_next = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_last      <= SRC_DBG;
            r_gpio_addr <= '0;
            r_gpio_data <= '0;
            r_gpio_en   <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_gnt_cpu) begin
                {r_gpio_addr, r_gpio_data} <= w_head;
                r_gpio_en <= 1'b1;
                r_last    <= SRC_CPU;
            end else if (w_gnt_dbg) begin
                r_gpio_addr <= bus.dbg_addr;
                r_gpio_data <= bus.dbg_data;
                r_gpio_en   <= 1'b1;
                r_last      <= SRC_DBG;
            end else if (r_state == SEND && bus.gpio_rdy) begin
                r_gpio_en <= 1'b0;
            end
            if (bus.cpu_en && w_full) r_ovf <= 1'b1;
        end
    end

    assign bus.cpu_stall = (w_count == CNT_W'(DEPTH));
    assign bus.cpu_ovf   = r_ovf;
    assign bus.dbg_gnt   = w_gnt_dbg;
    assign bus.GPIOaddr  = r_gpio_addr;
    assign bus.GPIO      = r_gpio_data;
    assign bus.GPIOEn    = r_gpio_en;

endmodule

// File: tb/tb_gpio_arbiter.sv
// Directed bench for gpio_arbiter: expected beats are queued at stimulus time and
// compared as the peripheral accepts them.
module tb_gpio_arbiter;
    import gpio_arb_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gpio_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    gpio_arbiter #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [AW+DW-1:0] exp_q [$];
    logic [AW+DW-1:0] mon_e;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_drive(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.cpu_en   = en;
        bus.cpu_addr = a;
        bus.cpu_data = d;
    endtask

    task automatic wait_drain(input string tag, input bit rand_rdy);
        int n = 0;
        while ((exp_q.size() != 0 || bus.GPIOEn) && n < 200) begin
            if (rand_rdy) bus.gpio_rdy = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk({tag, "_drain_done"}, 64'(n < 200), 64'(1));
    endtask

    // Scoreboard: a beat is consumed when GPIOEn and gpio_rdy meet.
    always @(negedge clk) begin
        if (!rst && bus.GPIOEn && bus.gpio_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL beat_unexpected: observed 0x%0h/0x%0h expected no beat", bus.GPIOaddr, bus.GPIO);
            end else begin
                mon_e = exp_q.pop_front();
                chk("beat", 64'({bus.GPIOaddr, bus.GPIO}), 64'(mon_e));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_seen;
        int gnt_cnt;
        logic gnt_en;
        int stable;
        int w;

        cpu_drive(1'b0, '0, '0);
        bus.dbg_req  = 1'b0;
        bus.dbg_addr = '0;
        bus.dbg_data = '0;
        bus.gpio_rdy = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_GPIOEn",   64'(bus.GPIOEn),    64'(0));
        chk("rst_GPIO",     64'(bus.GPIO),      64'(0));
        chk("rst_GPIOaddr", 64'(bus.GPIOaddr),  64'(0));
        chk("rst_dbg_gnt",  64'(bus.dbg_gnt),   64'(0));
        chk("rst_cpu_ovf",  64'(bus.cpu_ovf),   64'(0));
        chk("rst_stall",    64'(bus.cpu_stall), 64'(0));
        tick();
        rst = 1'b0;

        // Reset in the middle of a held beat, with a second entry still queued
        cpu_drive(1'b1, 32'h10, 8'h77);
        tick();
        cpu_drive(1'b1, 32'h14, 8'h78);
        tick();
        cpu_drive(1'b0, '0, '0);
        @(negedge clk);
        chk("midbeat_en",   64'(bus.GPIOEn),   64'(1));
        chk("midbeat_addr", 64'(bus.GPIOaddr), 64'(32'h10));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.gpio_rdy = 1'b1;
        @(negedge clk);
        chk("rst_mid_GPIOEn", 64'(bus.GPIOEn),    64'(0));
        chk("rst_mid_stall",  64'(bus.cpu_stall), 64'(0));
        chk("rst_mid_ovf",    64'(bus.cpu_ovf),   64'(0));
        en_seen = 0;
        repeat (4) begin
            tick();
            @(negedge clk);
            en_seen += int'(bus.GPIOEn);
        end
        chk("rst_fifo_empty", 64'(en_seen), 64'(0));

        // Single processor write, gpio_rdy high: GPIOEn only in n+2
        tick();
        cpu_drive(1'b1, 32'h20, 8'hA5);
        exp_q.push_back({32'h20, 8'hA5});
        @(negedge clk);
        chk("w1_n_en", 64'(bus.GPIOEn), 64'(0));
        tick();
        cpu_drive(1'b0, '0, '0);
        @(negedge clk);
        chk("w1_n1_en", 64'(bus.GPIOEn), 64'(0));
        tick();
        @(negedge clk);
        chk("w1_n2_en",   64'(bus.GPIOEn),   64'(1));
        chk("w1_n2_addr", 64'(bus.GPIOaddr), 64'(32'h20));
        chk("w1_n2_data", 64'(bus.GPIO),     64'(8'hA5));
        tick();
        @(negedge clk);
        chk("w1_n3_en", 64'(bus.GPIOEn), 64'(0));

        // Fill and overflow behind a held debug beat
        tick();
        bus.gpio_rdy = 1'b0;
        bus.dbg_req  = 1'b1;
        bus.dbg_addr = 32'hD0;
        bus.dbg_data = 8'hEE;
        exp_q.push_back({32'hD0, 8'hEE});
        @(negedge clk);
        chk("fill_dbg_gnt", 64'(bus.dbg_gnt), 64'(1));
        tick();
        bus.dbg_req = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            cpu_drive(1'b1, 32'h40 + 32'(i), 8'(i));
            if (i <= 4) exp_q.push_back({32'h40 + 32'(i), 8'(i)});
            @(negedge clk);
            chk($sformatf("fill_stall_%0d", i), 64'(bus.cpu_stall), 64'(i == 5));
            tick();
        end
        cpu_drive(1'b0, '0, '0);
        bus.gpio_rdy = 1'b1;
        @(negedge clk);
        chk("fill_ovf",        64'(bus.cpu_ovf),   64'(1));
        chk("fill_held_data",  64'(bus.GPIO),      64'(8'hEE));
        chk("fill_stall_held", 64'(bus.cpu_stall), 64'(1));
        tick();
        @(negedge clk);
        chk("fill_stall_pop_cycle", 64'(bus.cpu_stall), 64'(1));
        tick();
        @(negedge clk);
        chk("fill_stall_after_pop", 64'(bus.cpu_stall), 64'(0));
        wait_drain("fill", 1'b0);
        chk("fill_ovf_sticky", 64'(bus.cpu_ovf), 64'(1));

        // Simultaneous requests: expect 0x11, 0x99, 0x12
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.gpio_rdy = 1'b0;
        @(negedge clk);
        chk("sim_ovf_cleared", 64'(bus.cpu_ovf), 64'(0));
        tick();
        cpu_drive(1'b1, 32'h60, 8'h11);
        exp_q.push_back({32'h60, 8'h11});
        tick();
        cpu_drive(1'b1, 32'h62, 8'h12);
        tick();
        cpu_drive(1'b0, '0, '0);
        bus.dbg_req  = 1'b1;
        bus.dbg_addr = 32'h61;
        bus.dbg_data = 8'h99;
        exp_q.push_back({32'h61, 8'h99});
        exp_q.push_back({32'h62, 8'h12});
        @(negedge clk);
        chk("sim_no_gnt_in_send", 64'(bus.dbg_gnt), 64'(0));
        tick();
        bus.gpio_rdy = 1'b1;
        gnt_cnt = 0;
        gnt_en  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.dbg_gnt) begin
                gnt_cnt++;
                gnt_en = bus.GPIOEn;
            end
            tick();
            if (gnt_cnt > 0) bus.dbg_req = 1'b0;
        end
        chk("sim_gnt_pulses",   64'(gnt_cnt), 64'(1));
        chk("sim_gnt_in_idle",  64'(gnt_en),  64'(0));
        wait_drain("sim", 1'b0);

        // Backpressure: debug beat held 8 cycles while a processor write waits
        tick();
        bus.gpio_rdy = 1'b0;
        bus.dbg_req  = 1'b1;
        bus.dbg_addr = 32'h70;
        bus.dbg_data = 8'h55;
        exp_q.push_back({32'h70, 8'h55});
        @(negedge clk);
        chk("bp_dbg_gnt", 64'(bus.dbg_gnt), 64'(1));
        tick();
        bus.dbg_req = 1'b0;
        stable = 0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 2) begin
                cpu_drive(1'b1, 32'h80, 8'hC3);
                exp_q.push_back({32'h80, 8'hC3});
            end
            if (i == 3) cpu_drive(1'b0, '0, '0);
            if (i == 8) bus.gpio_rdy = 1'b1;
            @(negedge clk);
            if (bus.GPIOEn && bus.GPIO == 8'h55 && bus.GPIOaddr == 32'h70) stable++;
            tick();
        end
        chk("bp_stable_cycles", 64'(stable), 64'(8));
        @(negedge clk);
        chk("bp_en_fall", 64'(bus.GPIOEn), 64'(0));
        wait_drain("bp", 1'b0);

        // Wrap-around: 10 writes with random backpressure
        for (int i = 0; i < 10; i++) begin
            w = 0;
            while (bus.cpu_stall && w < 50) begin
                cpu_drive(1'b0, '0, '0);
                bus.gpio_rdy = 1'($urandom_range(0, 1));
                tick();
                w++;
            end
            chk($sformatf("wrap_stall_wait_%0d", i), 64'(w < 50), 64'(1));
            cpu_drive(1'b1, 32'h90 + 32'(i), 8'h30 + 8'(i));
            exp_q.push_back({32'h90 + 32'(i), 8'h30 + 8'(i)});
            bus.gpio_rdy = 1'($urandom_range(0, 1));
            tick();
        end
        cpu_drive(1'b0, '0, '0);
        wait_drain("wrap", 1'b1);
        chk("wrap_ovf",     64'(bus.cpu_ovf),  64'(0));
        chk("wrap_q_empty", 64'(exp_q.size()), 64'(0));
        bus.gpio_rdy = 1'b1;
        repeat (4) tick();
        chk("wrap_no_extra", 64'(bus.GPIOEn), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_arbiter.md
# gpio_arbiter

Shares the single GPIO output port between two requesters: the processor's store path (memory-controller GPIO writes) and a debug/boot-loader port. Processor writes are buffered in a small FIFO. The processor pipeline is stalled only when that FIFO is full. A round-robin arbiter grants the port to one source at a time. Each beat is held on the GPIO lines until the external peripheral acknowledges it with `gpio_rdy`. The block sits between the processor top level and the board-level GPIO pins.

## Interface
Parameters:
- `DEPTH`, default 4: processor write FIFO depth; power of two, ≥2.
- `ADDR_W`, default 32: GPIO address width.
- `DATA_W`, default 8: GPIO data width.

Ports:
- `clk`, input, 1: single clock; all state updates on rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `cpu_en`, input, 1: processor GPIO write strobe, one beat per cycle.
- `cpu_addr`, input, ADDR_W: processor GPIO address.
- `cpu_data`, input, DATA_W: processor GPIO data.
- `cpu_stall`, output, 1: FIFO full; pipeline must not issue a GPIO write.
- `cpu_ovf`, output, 1: sticky; a write arrived while full and was dropped.
- `dbg_req`, input, 1: debug write request, held until granted.
- `dbg_addr`, input, ADDR_W: debug address, stable while `dbg_req`.
- `dbg_data`, input, DATA_W: debug data, stable while `dbg_req`.
- `dbg_gnt`, output, 1: one-cycle pulse; debug beat captured this cycle.
- `gpio_rdy`, input, 1: peripheral accepts the current beat.
- `GPIOaddr`, output, ADDR_W: registered beat address.
- `GPIO`, output, DATA_W: registered beat data.
- `GPIOEn`, output, 1: beat valid; held until `gpio_rdy`.

## Operation
- **Reset values:**
  - `GPIOaddr`, `GPIO`, `GPIOEn`, `dbg_gnt` and `cpu_ovf` are 0.
  - `cpu_stall` is 0.
  - FIFO is empty, with count and pointers at 0.
  - State is IDLE and `last` is DBG, so the processor wins the first tie.
- **FIFO:**
  - Push when `cpu_en && !full`. Pop when the processor source is granted.
  - Push and pop in the same cycle are allowed and leave the count unchanged.
  - Pointers are `$clog2(DEPTH)` bits and wrap naturally.
  - `full` = (count == DEPTH). `cpu_stall` = `full`, computed combinationally from the registered count.
- **Overflow:** `cpu_en` while full drops the write and sets `cpu_ovf`. The flag is cleared only by `rst`.
- **States:**
  - IDLE:
    - Candidates are `cpu_pend` (= FIFO not empty) and `dbg_req`.
    - If both are pending, grant the source ≠ `last`. Otherwise grant the single pending source.
    - On a grant: load `GPIOaddr`/`GPIO` from the FIFO head or the debug inputs, set `GPIOEn`, update `last`, go to SEND.
    - A debug grant asserts `dbg_gnt` in this same cycle.
    - With nothing pending, stay in IDLE.
  - SEND:
    - `GPIOEn` = 1 and the outputs are frozen.
    - When `gpio_rdy`=1: clear `GPIOEn` at the edge and go to IDLE.
    - When `gpio_rdy`=0: stay in SEND, with no timeout.
- **Debug port:**
  - The requester must deassert `dbg_req` in the cycle after `dbg_gnt`.
  - `dbg_req` still high in that cycle is treated as a new request.
- **`gpio_rdy` outside SEND:** ignored.
- **Reset mid-beat:** the beat is abandoned. `GPIOEn` is 0 in the cycle after the `rst` edge, and the FIFO contents are discarded.

## Timing
- **Processor write latency:** a write with `cpu_en` in cycle n is visible in the FIFO in n+1. It is granted in n+1 if IDLE and uncontested, and `GPIOEn` rises in n+2.
- **Debug latency:** `dbg_req` in cycle n (IDLE, uncontested) gives `dbg_gnt` in n and `GPIOEn` from n+1.
- **Beat spacing:**
  - Minimum beat length is 1 cycle (`gpio_rdy` already high).
  - There is one mandatory IDLE cycle between beats, so peak throughput is 1 beat per 2 cycles.
- **Stall timing:**
  - `cpu_stall` rises in the cycle after the push that filled the FIFO.
  - It falls in the cycle after the pop that made room.
- **Output stability:** all GPIO outputs are registered, with no combinational path from inputs to `GPIOEn`/`GPIO`/`GPIOaddr`.

## Structure
- Package `gpio_arb_pkg`:
  - State enum `{IDLE, SEND}`.
  - Source enum `{SRC_CPU, SRC_DBG}`.
  - Default width constants `GPIO_ADDR_W`=32 and `GPIO_DATA_W`=8.
- Sub-module `gpio_fifo`:
  - Parameterized synchronous FIFO (`DEPTH`, width = `ADDR_W+DATA_W`).
  - Push/pop, `full`, `empty`, `count`, head data.
- The top level holds the arbiter FSM, the `last` register, the output registers and the overflow flag.

## Test plan
- **Reset:** assert `rst` during a SEND with `gpio_rdy`=0, beat addr 0x10 → next cycle `GPIOEn`=0, FIFO empty, `cpu_stall`=0, `cpu_ovf`=0.
- **Single processor write:** addr 0x20, data 0xA5, `gpio_rdy` tied 1 → `GPIOEn` high exactly in cycle n+2 with 0x20/0xA5, for one cycle.
- **Fill and overflow (DEPTH=4, `gpio_rdy`=0):**
  - Stimulus: five consecutive writes, data 0x01..0x05.
  - FIFO fill: `cpu_stall` rises after the fourth FIFO push; the fifth write is dropped and sets `cpu_ovf`=1.
  - Drain: release `gpio_rdy` → 0x01..0x04 emerge in order.
  - Recovery: `cpu_stall` drops after the first FIFO pop.
- **Simultaneous requests:** processor FIFO holds 0x11, 0x12 and `dbg_req` carries 0x99 at reset → grant order 0x11, 0x99, 0x12. `dbg_gnt` pulses once, in the IDLE cycle of the 0x99 grant.
- **Backpressure:** debug beat 0x55 with `gpio_rdy` low for 7 cycles → `GPIOEn` and `GPIO`=0x55 are stable for 8 cycles, then `GPIOEn` falls. No other grant occurs meanwhile.
- **Wrap-around:** 10 processor writes 0x30..0x39 with `gpio_rdy` toggling randomly → all 10 emerge in order, with no loss and no duplicates, and `cpu_ovf`=0.
